expr_eval_sched: RTL and testbench

//   Round-robin scheduler sharing one combinational expression-evaluator datapath
//   (60-bit operand bundle {a0..a5,b0..b5} in, 90-bit result out) among N_REQ requesters.
//   One transaction in flight. The block registers the granted operands onto the

---
 rtl/expr_eval_sched.sv | 154 +++++++++++++++
 tb/tb_expr_eval_sched.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/expr_eval_sched.sv
// -----------------------------------------------------------------------------
// expr_eval_sched
//   Round-robin scheduler that shares one combinational expression-evaluator
//   datapath among N_REQ requesters. Only one transaction is in flight at a time.
//   1. The winning requester's operand bundle is registered onto dp_operands.
//   2. The block waits LAT cycles.
//   3. dp_result is captured into rsp_data.
//   4. The result is returned to the owning requester.
//
// Handshake semantics (both channels):
//   A transfer happens on a rising clock edge where valid and ready are both
//   high. Requests: req_valid is the requester's offer. req_ready is the
//   scheduler's one-hot accept, and it is high only for the arbitration winner
//   while IDLE. Responses: rsp_valid is one-hot to the owner and stays high
//   with stable data until the owner's rsp_ready is seen. rsp_ready from
//   non-owners is ignored.
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   req_valid      per-requester request valid            [N_REQ]
//   req_ready      one-hot accept                         [N_REQ]
//   req_operands   bundle i at [i*OP_W +: OP_W]           [N_REQ*OP_W]
//   rsp_valid      one-hot response valid to owner        [N_REQ]
//   rsp_ready      per-requester response ready           [N_REQ]
//   rsp_data       captured datapath result               [RES_W]
//   dp_operands    registered operands to shared datapath [OP_W]
//   dp_result      datapath result (combinational)        [RES_W]
//   busy           high while a transaction is in flight
//   txn_count      completed responses, wraps             [CNT_W]
//   dbg_state      FSM state (0 IDLE, 1 WAIT, 2 RESP)     [2]
// -----------------------------------------------------------------------------
module expr_eval_sched #(
  parameter int N_REQ = 4,
  parameter int OP_W  = 60,
  parameter int RES_W = 90,
  parameter int LAT   = 2,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*OP_W-1:0]   req_operands,
  output logic [N_REQ-1:0]        rsp_valid,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic [RES_W-1:0]        rsp_data,
  output logic [OP_W-1:0]         dp_operands,
  input  logic [RES_W-1:0]        dp_result,
  output logic                    busy,
  output logic [CNT_W-1:0]        txn_count,
  output logic [1:0]              dbg_state
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int LAT_W = (LAT > 1) ? $clog2(LAT) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       state_q,  state_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] owner_q,  owner_d;
  logic [OP_W-1:0]  dp_q,     dp_d;
  logic [RES_W-1:0] rsp_q,    rsp_d;
  logic [LAT_W-1:0] cnt_q,    cnt_d;
  logic [CNT_W-1:0] txn_q,    txn_d;

  // Round-robin pick. The scan starts at rr_ptr and wraps modulo N_REQ.
  // The first valid requester found in that order wins.
  logic             found;
  logic [PTR_W-1:0] winner;
  logic [PTR_W-1:0] idx;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = PTR_W'((int'(rr_ptr_q) + k) % N_REQ);
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    dp_d     = dp_q;
    rsp_d    = rsp_q;
    cnt_d    = cnt_q;
    txn_d    = txn_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          dp_d    = req_operands[int'(winner)*OP_W +: OP_W];
          owner_d = winner;
          cnt_d   = LAT_W'(LAT - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          rsp_d   = dp_result;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready[owner_q]) begin
          txn_d    = txn_q + 1'b1;
          rr_ptr_d = PTR_W'((int'(owner_q) + 1) % N_REQ);
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      dp_q     <= '0;
      rsp_q    <= '0;
      cnt_q    <= '0;
      txn_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      dp_q     <= dp_d;
      rsp_q    <= rsp_d;
      cnt_q    <= cnt_d;
      txn_q    <= txn_d;
    end
  end

  // req_ready is combinational from req_valid. It is gated by rst_n so that
  // every output is low while reset is held.
  assign req_ready   = (rst_n && state_q == S_IDLE && found) ? (N_REQ'(1) << winner) : '0;
  assign rsp_valid   = (state_q == S_RESP) ? (N_REQ'(1) << owner_q) : '0;
  assign rsp_data    = rsp_q;
  assign dp_operands = dp_q;
  assign busy        = (state_q != S_IDLE);
  assign txn_count   = txn_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_expr_eval_sched.sv
module tb_expr_eval_sched;

  localparam int N    = 4;
  localparam int OPW  = 60;
  localparam int RESW = 90;
  localparam int LAT  = 2;
  localparam int CW   = 4;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      rsp_ready = '0;
  logic [N*OPW-1:0]  req_operands = '0;
  logic [N-1:0]      req_ready, rsp_valid;
  logic [RESW-1:0]   rsp_data, dp_result;
  logic [OPW-1:0]    dp_operands;
  logic              busy;
  logic [CW-1:0]     txn_count;
  logic [1:0]        dbg_state;

  always #5 clk = ~clk;

  // Stub datapath: result is the zero-extended operand bundle.
  assign dp_result = {30'd0, dp_operands};

  expr_eval_sched #(.N_REQ(N), .OP_W(OPW), .RES_W(RESW), .LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_operands(req_operands),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .dp_operands(dp_operands), .dp_result(dp_result),
    .busy(busy), .txn_count(txn_count), .dbg_state(dbg_state)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Transaction view: an accepted request is in flight for LAT cycles after
  // its grant, then answers until its owner is ready.
  int              m_owner;   // -1 when nothing is in flight
  int              m_age;     // cycles elapsed since the grant
  int              m_ptr;
  int              m_count;
  logic [OPW-1:0]  m_dp;
  logic [RESW-1:0] m_rsp;
  logic [RESW-1:0] exp_q[$];

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [OPW-1:0] bundle_of(input int i);
    return req_operands[i*OPW +: OPW];
  endfunction

  task automatic model_reset();
    m_owner = -1; m_age = 0; m_ptr = 0; m_count = 0;
    m_dp = '0; m_rsp = '0;
    exp_q.delete();
  endtask

  // Checks one cycle at the falling edge, then advances the model across
  // the next rising edge. Inputs change only at posedge+1.
  task automatic step();
    int w;
    logic [N-1:0] e_rr, e_rv;
    @(negedge clk);
    w    = pick();
    e_rr = (m_owner < 0 && w >= 0) ? N'(1 << w) : '0;
    e_rv = (m_owner >= 0 && m_age > LAT) ? N'(1 << m_owner) : '0;
    check("req_ready", req_ready, e_rr);
    check("rsp_valid", rsp_valid, e_rv);
    check("busy", busy, m_owner >= 0);
    check("dp_operands", dp_operands, m_dp);
    check("rsp_data", rsp_data, m_rsp);
    check("txn_count", txn_count, 96'(m_count % (1 << CW)));
    if (m_owner < 0) begin
      if (w >= 0) begin
        m_owner = w; m_age = 1; m_dp = bundle_of(w);
        exp_q.push_back({30'd0, bundle_of(w)});
      end
    end else if (m_age <= LAT) begin
      if (m_age == LAT) m_rsp = {30'd0, m_dp};
      m_age++;
    end else if (rsp_ready[m_owner]) begin
      check("sb_depth", exp_q.size(), 1);
      if (exp_q.size() > 0) check("sb_data", rsp_data, exp_q.pop_front());
      m_count++;
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
    end
    @(posedge clk); #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_bundle(input int i, input logic [OPW-1:0] v);
    req_operands[i*OPW +: OPW] = v;
  endtask

  function automatic logic [OPW-1:0] rand_bundle();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[OPW-1:0];
  endfunction

  // Asserts reset asynchronously, checks that outputs clear at once,
  // then releases just after the next rising edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_rsp_valid", rsp_valid, '0);
    check("rst_req_ready", req_ready, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_dp", dp_operands, '0);
    check("rst_rsp_data", rsp_data, '0);
    check("rst_txn", txn_count, '0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Single request from requester 2.
    req_valid = 4'b0100; set_bundle(2, 60'h123); rsp_ready = 4'hF;
    step();
    req_valid = '0;
    repeat (4) step();

    // All requesters busy: rotation 0,1,2,3,0.
    for (int i = 0; i < N; i++) set_bundle(i, rand_bundle());
    req_valid = 4'hF; rsp_ready = 4'hF;
    repeat (20) step();
    req_valid = '0;
    repeat (4) step();

    // Owner stalls the response, then completes it.
    req_valid = 4'b0001; set_bundle(0, rand_bundle()); rsp_ready = 4'b1110;
    repeat (16) step();
    rsp_ready = 4'hF; req_valid = '0;
    repeat (3) step();

    // Bundle changes after the grant must not reach the result.
    req_valid = 4'b0001; set_bundle(0, 60'hA); rsp_ready = 4'hF;
    step();
    set_bundle(0, 60'hB); req_valid = '0;
    repeat (4) step();

    // Reset while a transaction is waiting on the datapath.
    req_valid = 4'b0100; set_bundle(2, rand_bundle());
    step();
    req_valid = '0;
    step();
    do_reset();
    req_valid = 4'b1010; set_bundle(1, rand_bundle()); set_bundle(3, rand_bundle());
    step();
    req_valid = '0;
    repeat (4) step();

    // Random traffic: many transactions, so txn_count wraps several times.
    for (int c = 0; c < 500; c++) begin
      req_valid = N'($urandom_range(0, 15));
      rsp_ready = N'($urandom_range(0, 15));
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 3) == 0) set_bundle(i, rand_bundle());
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
